seq_div8: RTL and testbench



---
 rtl/seq_div8.sv | 135 +++++++++++++
 tb/tb_seq_div8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_div8.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per cycle, MSB first.
// Optional SEQ_DIV8_ERR_EN adds an err port and a one-cycle divide-by-zero shortcut.
module seq_div8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] q,
  output logic [7:0] r,
  output logic       busy,
  output logic       done
`ifdef SEQ_DIV8_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [8:0] rem_q, rem_d;
  logic [7:0] quo_q, quo_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] q_q, q_d;
  logic [7:0] r_q, r_d;
`ifdef SEQ_DIV8_ERR_EN
  logic       err_q, err_d;
`endif

  logic [8:0] shifted;
  logic [9:0] diff;
  logic       no_borrow;
  logic       unused_rem_msb;

  // Trial subtraction as shifted + ~b + 1; bit 9 is the carry-out (1 means no borrow).
  assign shifted        = {rem_q[7:0], a_q[cnt_q]};
  assign diff           = {1'b0, shifted} + {2'b01, ~b_q} + 10'd1;
  assign no_borrow      = diff[9];
  assign unused_rem_msb = rem_q[8];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef SEQ_DIV8_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          rem_d   = 9'd0;
          quo_d   = 8'd0;
          cnt_d   = 3'd7;
          state_d = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
`ifdef SEQ_DIV8_ERR_EN
        if (b_q == 8'd0) begin
          q_d     = 8'hff;
          r_d     = a_q;
          err_d   = 1'b1;
          state_d = StDone;
        end else
`endif
        begin
          if (no_borrow) begin
            rem_d        = diff[8:0];
            quo_d[cnt_q] = 1'b1;
          end else begin
            rem_d        = shifted;
            quo_d[cnt_q] = 1'b0;
          end
          if (cnt_q == 3'd0) begin
            q_d     = quo_d;
            r_d     = rem_d[7:0];
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      rem_q   <= 9'd0;
      quo_q   <= 8'd0;
      cnt_q   <= 3'd0;
      q_q     <= 8'd0;
      r_q     <= 8'd0;
`ifdef SEQ_DIV8_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef SEQ_DIV8_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = (state_q == StBusy);
  assign done = (state_q == StDone);
`ifdef SEQ_DIV8_ERR_EN
  assign err  = err_q;
`endif

endmodule

// File: tb/tb_seq_div8.sv
// Self-checking bench for seq_div8: directed table, back-to-back, reset abort, random sweep.
module tb_seq_div8;

`ifdef SEQ_DIV8_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] a, b, q, r;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  seq_div8 dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done)
`ifdef SEQ_DIV8_ERR_EN
    ,
    .err  (err)
`endif
  );

`ifndef SEQ_DIV8_ERR_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one division, scramble operands after acceptance, wait (bounded) for done.
  task automatic run_div(input logic [7:0] ai, input logic [7:0] bi, output int lat,
                         output int nbusy, output logic [7:0] qo, output logic [7:0] ro,
                         output logic eo);
    a = ai;
    b = bi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    lat = -1;
    nbusy = busy ? 1 : 0;
    qo = 8'hxx;
    ro = 8'hxx;
    eo = 1'bx;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        qo  = q;
        ro  = r;
        eo  = err;
      end else if (busy) begin
        nbusy++;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (busy || done); i++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic int exp_lat(input logic [7:0] bi);
    return (ErrEn && bi == 8'd0) ? 1 : 8;
  endfunction

  vec_t       tbl[9];
  int         lat, nbusy, last, nres, npulse;
  logic [7:0] qo, ro, ai, bi, mq, mr;
  logic       eo;

  initial begin
    tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4};
    tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
    tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5};
    tbl[3] = '{8'd100, 8'd0,   8'hff,  8'd100};
    tbl[4] = '{8'd81,  8'd9,   8'd9,   8'd0};
    tbl[5] = '{8'd17,  8'd5,   8'd3,   8'd2};
    tbl[6] = '{8'd0,   8'd5,   8'd0,   8'd0};
    tbl[7] = '{8'd255, 8'd255, 8'd1,   8'd0};
    tbl[8] = '{8'd254, 8'd255, 8'd0,   8'd254};

    reset = 1'b1;
    start = 1'b0;
    a = 8'd0;
    b = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", q, 0);
    check("reset_r", r, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_div(tbl[i].a, tbl[i].b, lat, nbusy, qo, ro, eo);
      check($sformatf("tbl%0d_q", i), qo, tbl[i].q);
      check($sformatf("tbl%0d_r", i), ro, tbl[i].r);
      check($sformatf("tbl%0d_lat", i), lat, exp_lat(tbl[i].b));
      check($sformatf("tbl%0d_busy", i), nbusy, exp_lat(tbl[i].b));
      check($sformatf("tbl%0d_err", i), eo, ErrEn && tbl[i].b == 8'd0);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_pulse", i), done, 0);
    end

    // start held high: results every 9 cycles, mid-run start/operand noise ignored
    a = 8'd81;
    b = 8'd9;
    start = 1'b1;
    last = -1;
    nres = 0;
    for (int i = 1; i <= 40 && nres < 3; i++) begin
      @(posedge clk); #1;
      if (done) begin
        check("b2b_q", q, 9);
        check("b2b_r", r, 0);
        check("b2b_gap", (last < 0) ? i : i - last, 9);
        last = i;
        nres++;
        a = 8'd81;
        b = 8'd9;
      end else if (busy) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end
    start = 1'b0;
    check("b2b_count", nres, 3);
    drain();

    // reset during the 4th busy cycle aborts with no done pulse
    a = 8'd200;
    b = 8'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_q", q, 0);
    check("abort_r", r, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) npulse++;
    end
    check("abort_no_pulse", npulse, 0);
    run_div(8'd17, 8'd5, lat, nbusy, qo, ro, eo);
    check("post_abort_q", qo, 3);
    check("post_abort_r", ro, 2);
    check("post_abort_lat", lat, 8);

    // random sweep against plain-arithmetic model
    for (int i = 0; i < 1000; i++) begin
      ai = 8'($urandom_range(0, 255));
      bi = (i % 100 == 7) ? 8'd0 : 8'($urandom_range(0, 255));
      if (bi == 8'd0) begin
        mq = 8'hff;
        mr = ai;
      end else begin
        mq = ai / bi;
        mr = ai % bi;
      end
      run_div(ai, bi, lat, nbusy, qo, ro, eo);
      check($sformatf("rand_q %0d/%0d", ai, bi), qo, mq);
      check($sformatf("rand_r %0d/%0d", ai, bi), ro, mr);
      check($sformatf("rand_lat %0d/%0d", ai, bi), lat, exp_lat(bi));
      check($sformatf("rand_err %0d/%0d", ai, bi), eo, ErrEn && bi == 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
